// File: rtl/mbtrain_txselfcal_handshake.sv
// MBTRAIN.TXSELFCAL sideband handshake: an initiator FSM that calibrates the local
// transmitter and a responder FSM that answers the partner, sharing one sideband issue port.
module mbtrain_txselfcal_handshake #(
    parameter int CAL_CYCLES     = 64,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [3:0] i_decoded_sideband_message,
    input  logic       i_sideband_valid,
    input  logic       i_busy,
    output logic [3:0] o_sideband_message,
    output logic       o_valid,
    output logic       o_cal_en,
    output logic       o_test_ack,
    output logic       o_error
);

    localparam logic [3:0] MSG_START_REQ  = 4'd1;
    localparam logic [3:0] MSG_START_RESP = 4'd2;
    localparam logic [3:0] MSG_DONE_REQ   = 4'd3;
    localparam logic [3:0] MSG_DONE_RESP  = 4'd4;

    localparam logic [CNT_W-1:0] CAL_LAST = CNT_W'(CAL_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        I_IDLE,
        I_START_REQ,
        I_WAIT_START_RESP,
        I_CAL,
        I_DONE_REQ,
        I_WAIT_DONE_RESP,
        I_DONE
    } init_state_t;

    typedef enum logic [2:0] {
        R_IDLE,
        R_START_RESP,
        R_WAIT_DONE_REQ,
        R_DONE_RESP,
        R_DONE
    } resp_state_t;

    init_state_t      init_state;
    init_state_t      init_next;
    resp_state_t      resp_state;
    resp_state_t      resp_next;

    logic [CNT_W-1:0] cal_cnt;
    logic [CNT_W-1:0] to_cnt;
    logic             error_q;
    logic             valid_q;
    logic [3:0]       msg_q;

    logic             rx_start_req;
    logic             rx_start_resp;
    logic             rx_done_req;
    logic             rx_done_resp;

    logic             init_pend;
    logic [3:0]       init_code;
    logic             resp_pend;
    logic [3:0]       resp_code;
    logic             can_issue;
    logic             init_issue;
    logic             resp_issue;

    logic             to_run;
    logic             timeout_hit;
    logic             freeze;
    logic             state_change;

    // Receive decode: a single valid message is offered to both FSMs at once.
    always_comb begin
        rx_start_req  = i_sideband_valid && (i_decoded_sideband_message == MSG_START_REQ);
        rx_start_resp = i_sideband_valid && (i_decoded_sideband_message == MSG_START_RESP);
        rx_done_req   = i_sideband_valid && (i_decoded_sideband_message == MSG_DONE_REQ);
        rx_done_resp  = i_sideband_valid && (i_decoded_sideband_message == MSG_DONE_RESP);
    end

    // Issue arbitration: the responder wins a tie, and a gap cycle always follows a strobe.
    always_comb begin
        init_pend  = 1'b0;
        init_code  = MSG_START_REQ;
        resp_pend  = 1'b0;
        resp_code  = MSG_START_RESP;

        case (init_state)
            I_START_REQ: begin
                init_pend = 1'b1;
                init_code = MSG_START_REQ;
            end
            I_DONE_REQ: begin
                init_pend = 1'b1;
                init_code = MSG_DONE_REQ;
            end
            default: ;
        endcase

        case (resp_state)
            R_START_RESP: begin
                resp_pend = 1'b1;
                resp_code = MSG_START_RESP;
            end
            R_DONE_RESP: begin
                resp_pend = 1'b1;
                resp_code = MSG_DONE_RESP;
            end
            default: ;
        endcase

        can_issue  = !valid_q && !i_busy && !error_q;
        resp_issue = can_issue && resp_pend;
        init_issue = can_issue && init_pend && !resp_pend;
    end

    // Partner-wait timeout; the responder only waits once our own handshake is underway.
    always_comb begin
        to_run = (init_state == I_WAIT_START_RESP) ||
                 (init_state == I_WAIT_DONE_RESP)  ||
                 (((resp_state == R_IDLE) || (resp_state == R_WAIT_DONE_REQ)) &&
                  (init_state != I_IDLE));
        timeout_hit = to_run && (to_cnt == TO_LAST) && !error_q;
        freeze      = error_q || timeout_hit;
    end

    always_comb begin
        init_next = init_state;
        if (!freeze) begin
            case (init_state)
                I_IDLE:            init_next = I_START_REQ;
                I_START_REQ:       if (init_issue)    init_next = I_WAIT_START_RESP;
                I_WAIT_START_RESP: if (rx_start_resp) init_next = I_CAL;
                I_CAL:             if (cal_cnt == CAL_LAST) init_next = I_DONE_REQ;
                I_DONE_REQ:        if (init_issue)    init_next = I_WAIT_DONE_RESP;
                I_WAIT_DONE_RESP:  if (rx_done_resp)  init_next = I_DONE;
                I_DONE:            init_next = I_DONE;
                default:           init_next = I_IDLE;
            endcase
        end
    end

    always_comb begin
        resp_next = resp_state;
        if (!freeze) begin
            case (resp_state)
                R_IDLE:          if (rx_start_req) resp_next = R_START_RESP;
                R_START_RESP:    if (resp_issue)   resp_next = R_WAIT_DONE_REQ;
                R_WAIT_DONE_REQ: if (rx_done_req)  resp_next = R_DONE_RESP;
                R_DONE_RESP:     if (resp_issue)   resp_next = R_DONE;
                R_DONE:          resp_next = R_DONE;
                default:         resp_next = R_IDLE;
            endcase
        end
    end

    assign state_change = (init_next != init_state) || (resp_next != resp_state);

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            init_state <= I_IDLE;
            resp_state <= R_IDLE;
            cal_cnt    <= '0;
            to_cnt     <= '0;
            error_q    <= 1'b0;
            valid_q    <= 1'b0;
            msg_q      <= 4'd0;
        end else begin
            init_state <= init_next;
            resp_state <= resp_next;

            if (init_next != init_state) begin
                cal_cnt <= '0;
            end else if ((init_state == I_CAL) && !freeze) begin
                cal_cnt <= cal_cnt + CNT_ONE;
            end

            if (state_change) begin
                to_cnt <= '0;
            end else if (to_run && !freeze) begin
                to_cnt <= to_cnt + CNT_ONE;
            end

            error_q <= error_q || timeout_hit;
            valid_q <= resp_issue || init_issue;

            // The message register holds its last code between strobes.
            if (resp_issue) begin
                msg_q <= resp_code;
            end else if (init_issue) begin
                msg_q <= init_code;
            end
        end
    end

    assign o_sideband_message = msg_q;
    assign o_valid            = valid_q;
    assign o_cal_en           = (init_state == I_CAL);
    assign o_test_ack         = (init_state == I_DONE) && (resp_state == R_DONE);
    assign o_error            = error_q;

endmodule

// File: tb/tb_mbtrain_txselfcal_handshake.sv
// Scoreboard bench for mbtrain_txselfcal_handshake: expected sideband codes are queued
// as stimulus is driven and popped whenever the DUT strobes o_valid.
module tb_mbtrain_txselfcal_handshake;

    logic       clk;
    logic       rst;
    logic       i_en;
    logic [3:0] i_decoded_sideband_message;
    logic       i_sideband_valid;
    logic       i_busy;
    logic [3:0] o_sideband_message;
    logic       o_valid;
    logic       o_cal_en;
    logic       o_test_ack;
    logic       o_error;

    logic [3:0] exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       prev_valid = 1'b0;

    mbtrain_txselfcal_handshake #(
        .CAL_CYCLES     (64),
        .TIMEOUT_CYCLES (4096),
        .CNT_W          (13)
    ) dut (
        .clk                        (clk),
        .rst                        (rst),
        .i_en                       (i_en),
        .i_decoded_sideband_message (i_decoded_sideband_message),
        .i_sideband_valid           (i_sideband_valid),
        .i_busy                     (i_busy),
        .o_sideband_message         (o_sideband_message),
        .o_valid                    (o_valid),
        .o_cal_en                   (o_cal_en),
        .o_test_ack                 (o_test_ack),
        .o_error                    (o_error)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (compared %0d, mismatched %0d)", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every strobe pops one expected code; strobes must never be adjacent.
    always @(negedge clk) begin
        if (!rst && o_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'(o_valid), 32'd0);
            end else begin
                check("issued_code", 32'(o_sideband_message), 32'(exp_q.pop_front()));
            end
            check("back_to_back", 32'(prev_valid), 32'd0);
        end
        prev_valid <= o_valid;
    end

    // Driver tasks (all called at a negedge, return at a negedge)
    task automatic do_reset();
        rst = 1'b1;
        i_en = 1'b0;
        i_sideband_valid = 1'b0;
        i_decoded_sideband_message = 4'd0;
        i_busy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_msg", 32'(o_sideband_message), 32'd0);
        check("rst_cal_en", 32'(o_cal_en), 32'd0);
        check("rst_ack", 32'(o_test_ack), 32'd0);
        check("rst_error", 32'(o_error), 32'd0);
        check("leftover_expect", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send(input logic [3:0] code);
        i_sideband_valid = 1'b1;
        i_decoded_sideband_message = code;
        @(negedge clk);
        i_sideband_valid = 1'b0;
        i_decoded_sideband_message = 4'd0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!o_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(o_valid), 32'd1);
    endtask

    task automatic idle_check(input string tag, input int cycles);
        int pulses = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (o_valid) pulses++;
        end
        check(tag, 32'(pulses), 32'd0);
    endtask

    initial begin
        int n;

        // Normal flow with out-of-order codes mixed in
        do_reset();
        i_en = 1'b1;
        exp_q.push_back(4'd1);
        @(negedge clk);
        send(4'd3);
        wait_valid("start_req_seen", 4);
        @(negedge clk);
        send(4'd7);
        idle_check("ooo_no_valid", 4);
        check("ooo_no_cal", 32'(o_cal_en), 32'd0);
        exp_q.push_back(4'd3);
        send(4'd2);
        n = 0;
        while (o_cal_en && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("cal_len", 32'(n), 32'd64);
        wait_valid("done_req_seen", 4);
        @(negedge clk);
        check("msg_hold", 32'(o_sideband_message), 32'd3);
        check("valid_one_cycle", 32'(o_valid), 32'd0);
        exp_q.push_back(4'd2);
        send(4'd1);
        wait_valid("start_resp_seen", 4);
        @(negedge clk);
        send(4'd7);
        exp_q.push_back(4'd4);
        send(4'd3);
        wait_valid("done_resp_seen", 4);
        check("ack_before_done_resp", 32'(o_test_ack), 32'd0);
        @(negedge clk);
        send(4'd4);
        check("ack_done", 32'(o_test_ack), 32'd1);
        check("err_done", 32'(o_error), 32'd0);
        idle_check("done_quiet", 5);
        check("ack_sticky", 32'(o_test_ack), 32'd1);

        // Collision: partner START_REQ lands as the initiator posts its own
        do_reset();
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd1);
        i_en = 1'b1;
        send(4'd1);
        wait_valid("collision_first", 4);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_valid && n < 10);
        check("collision_gap", 32'(n), 32'd2);
        idle_check("collision_quiet", 4);

        // Busy stall
        do_reset();
        i_busy = 1'b1;
        i_en = 1'b1;
        exp_q.push_back(4'd1);
        idle_check("busy_hold", 20);
        i_busy = 1'b0;
        @(negedge clk);
        check("busy_release", 32'(o_valid), 32'd1);
        @(negedge clk);
        check("busy_single", 32'(o_valid), 32'd0);

        // Timeout: START_REQ never answered
        do_reset();
        i_en = 1'b1;
        exp_q.push_back(4'd1);
        wait_valid("to_start_req", 4);
        n = 0;
        while (!o_error && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("to_latency", 32'(n), 32'd4096);
        check("to_no_ack", 32'(o_test_ack), 32'd0);
        idle_check("to_frozen", 30);
        check("to_sticky", 32'(o_error), 32'd1);
        check("to_no_ack_later", 32'(o_test_ack), 32'd0);

        // Reset during the calibration window
        do_reset();
        i_en = 1'b1;
        exp_q.push_back(4'd1);
        wait_valid("mr_start_req", 4);
        @(negedge clk);
        send(4'd2);
        repeat (29) @(negedge clk);
        check("mr_cal_active", 32'(o_cal_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mr_valid", 32'(o_valid), 32'd0);
        check("mr_msg", 32'(o_sideband_message), 32'd0);
        check("mr_cal_en", 32'(o_cal_en), 32'd0);
        check("mr_ack", 32'(o_test_ack), 32'd0);
        check("mr_error", 32'(o_error), 32'd0);
        rst = 1'b0;
        exp_q.push_back(4'd1);
        wait_valid("mr_restart", 6);
        check("mr_restart_no_cal", 32'(o_cal_en), 32'd0);
        repeat (3) @(negedge clk);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
